// File: rtl/mac_acc_pkg.sv
// Shared definitions for the multi-channel accumulator bank: operation codes,
// drain sequencer states and saturation limits as functions of accumulator width.
package mac_acc_pkg;

  localparam logic [1:0] OP_NOP  = 2'd0;
  localparam logic [1:0] OP_LOAD = 2'd1;
  localparam logic [1:0] OP_ACC  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Limits are returned in a wide word; callers keep the low acc_w bits.
  function automatic logic [63:0] sat_max(input int unsigned acc_w);
    return (64'd1 << (acc_w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min(input int unsigned acc_w);
    return ~sat_max(acc_w);
  endfunction

endpackage

// File: rtl/acc_sat_add.sv
// Signed accumulate adder with overflow detect. Define SATURATE_EN to clamp
// the result on overflow; otherwise the two's-complement sum wraps.
module acc_sat_add
  import mac_acc_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int ACC_W  = 16
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [DATA_W-1:0] data,
  output logic [ACC_W-1:0]  sum,
  output logic              ovf
);

  logic signed [ACC_W:0] wide;

  // One guard bit: the top two bits differ exactly when the ACC_W-bit result overflowed.
  assign wide = (ACC_W+1)'($signed(acc)) + (ACC_W+1)'($signed(data));
  assign ovf  = wide[ACC_W] ^ wide[ACC_W-1];

`ifdef SATURATE_EN
  localparam logic [63:0] MAX_W = sat_max(ACC_W);
  localparam logic [63:0] MIN_W = sat_min(ACC_W);

  always_comb begin
    sum = wide[ACC_W-1:0];
    if (ovf) sum = wide[ACC_W] ? MIN_W[ACC_W-1:0] : MAX_W[ACC_W-1:0];
  end
`else
  assign sum = wide[ACC_W-1:0];
`endif

endmodule

// File: rtl/mac_acc_bank.sv
// Multi-channel accumulator bank with load/accumulate input handshake, a drain
// sequencer that streams and clears every channel, and a random-access read port.
module mac_acc_bank
  import mac_acc_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int ACC_W  = 16,
  parameter int NUM_CH = 4,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [CH_W-1:0]   in_ch,
  input  logic [DATA_W-1:0] in_data,
  input  logic              drain,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CH_W-1:0]   out_ch,
  output logic [ACC_W-1:0]  out_data,
  output logic              drain_done,
  input  logic [CH_W-1:0]   rd_ch,
  output logic [ACC_W-1:0]  rd_data,
  output logic [NUM_CH-1:0] ovf
);

  logic [ACC_W-1:0] acc_q [NUM_CH];
  logic [CH_W-1:0]  idx;
  state_t           state, state_nxt;

  logic             in_fire, out_fire, last_ch;
  logic [ACC_W-1:0] add_sum, load_val;
  logic             add_ovf;

  assign in_ready = (state == S_IDLE) & ~drain & rst;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign last_ch  = (idx == CH_W'(NUM_CH - 1));
  assign load_val = ACC_W'($signed(in_data));

  assign out_ch   = idx;
  assign out_data = acc_q[idx];
  assign rd_data  = acc_q[rd_ch];

  // A single adder serves every channel; the selected channel feeds it.
  acc_sat_add #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_add (
    .acc  (acc_q[in_ch]),
    .data (in_data),
    .sum  (add_sum),
    .ovf  (add_ovf)
  );

  always_comb begin
    state_nxt  = state;
    out_valid  = 1'b0;
    drain_done = 1'b0;
    unique case (state)
      S_IDLE:  if (drain) state_nxt = S_DRAIN;
      S_DRAIN: begin
        out_valid = 1'b1;
        if (out_ready && last_ch) state_nxt = S_DONE;
      end
      S_DONE: begin
        drain_done = 1'b1;
        state_nxt  = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && drain) idx <= '0;
      else if (out_fire)            idx <= idx + 1'b1;
    end
  end

  // NOTE: the accumulator array is a register file that must read as zero after
  // reset, so every entry is cleared here rather than left to a RAM macro.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CH; i++) acc_q[i] <= '0;
      ovf <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (in_fire && in_ch == CH_W'(i)) begin
          case (in_op)
            OP_LOAD: begin
              acc_q[i] <= load_val;
              ovf[i]   <= 1'b0;
            end
            OP_ACC: begin
              acc_q[i] <= add_sum;
              if (add_ovf) ovf[i] <= 1'b1;
            end
            default: ;
          endcase
        end else if (out_fire && idx == CH_W'(i)) begin
          acc_q[i] <= '0;
          ovf[i]   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_acc_bank.sv
// Self-checking bench for mac_acc_bank against an integer reference model of
// the channel bank; honours SATURATE_EN the same way the design does.
module tb_mac_acc_bank;

  localparam int DATA_W = 12;
  localparam int ACC_W  = 16;
  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;
  localparam int AMAX   = 32767;
  localparam int AMIN   = -32768;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_op;
  logic [CH_W-1:0]   in_ch;
  logic [DATA_W-1:0] in_data;
  logic              drain;
  logic              out_valid;
  logic              out_ready;
  logic [CH_W-1:0]   out_ch;
  logic [ACC_W-1:0]  out_data;
  logic              drain_done;
  logic [CH_W-1:0]   rd_ch;
  logic [ACC_W-1:0]  rd_data;
  logic [NUM_CH-1:0] ovf;

  mac_acc_bank #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .NUM_CH (NUM_CH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_ch      (in_ch),
    .in_data    (in_data),
    .drain      (drain),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_ch     (out_ch),
    .out_data   (out_data),
    .drain_done (drain_done),
    .rd_ch      (rd_ch),
    .rd_data    (rd_data),
    .ovf        (ovf)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int model_acc [NUM_CH];
  bit model_ovf [NUM_CH];

  function automatic int fit(input int s);
`ifdef SATURATE_EN
    if (s > AMAX) return AMAX;
    if (s < AMIN) return AMIN;
    return s;
`else
    int w;
    w = s & 32'hFFFF;
    return (w >= 32768) ? w - 65536 : w;
`endif
  endfunction

  function automatic logic [31:0] w16(input int v);
    return {16'h0, v[15:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      model_acc[c] = 0;
      model_ovf[c] = 1'b0;
    end
  endtask

  task automatic check_bank(input string tag);
    logic [NUM_CH-1:0] e;
    for (int c = 0; c < NUM_CH; c++) begin
      rd_ch = CH_W'(c);
      #1;
      check($sformatf("%s_rd%0d", tag, c), {16'h0, rd_data}, w16(model_acc[c]));
      e[c] = model_ovf[c];
    end
    check({tag, "_ovf"}, {28'h0, ovf}, {28'h0, e});
  endtask

  // Called at a falling edge; returns at a falling edge with the op retired.
  task automatic do_op(input int o, input int ch, input int d);
    int waited;
    int s;
    in_valid = 1'b1;
    in_op    = 2'(o);
    in_ch    = CH_W'(ch);
    in_data  = d[DATA_W-1:0];
    waited   = 0;
    #1;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!in_ready) check("in_ready_timeout", {31'h0, in_ready}, 32'h1);
    else begin
      @(posedge clk);
      if (o == 1) begin
        model_acc[ch] = d;
        model_ovf[ch] = 1'b0;
      end else if (o == 2) begin
        s = model_acc[ch] + d;
        if (s > AMAX || s < AMIN) model_ovf[ch] = 1'b1;
        model_acc[ch] = fit(s);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_op    = 2'd0;
  endtask

  task automatic pulse_drain(input bit collide);
    drain = 1'b1;
    if (collide) begin
      in_valid = 1'b1;
      in_op    = 2'd1;
      in_ch    = '0;
      in_data  = 12'd99;
    end
    #1;
    check("drain_blocks_ready", {31'h0, in_ready}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    drain    = 1'b0;
    in_valid = 1'b0;
  endtask

  // Streams stop_n words; with toggle the sink stalls every other cycle.
  task automatic run_drain(input bit toggle, input int stop_n);
    int n;
    int cyc;
    n   = 0;
    cyc = 0;
    while (n < stop_n && cyc < 64) begin
      #1;
      check("drain_valid", {31'h0, out_valid}, 32'h1);
      check("drain_ch", {30'h0, out_ch}, 32'(n));
      check("drain_data", {16'h0, out_data}, w16(model_acc[n]));
      check("drain_done_early", {31'h0, drain_done}, 32'h0);
      out_ready = toggle ? (cyc % 2 == 1) : 1'b1;
      @(posedge clk);
      if (out_ready) begin
        model_acc[n] = 0;
        model_ovf[n] = 1'b0;
        n++;
      end
      @(negedge clk);
      out_ready = 1'b0;
      cyc++;
    end
    if (n < stop_n) check("drain_progress", 32'(n), 32'(stop_n));
  endtask

  task automatic finish_drain(input string tag);
    #1;
    check({tag, "_done_pulse"}, {31'h0, drain_done}, 32'h1);
    check({tag, "_valid_off"}, {31'h0, out_valid}, 32'h0);
    @(negedge clk);
    #1;
    check({tag, "_done_clear"}, {31'h0, drain_done}, 32'h0);
    check({tag, "_idle_ready"}, {31'h0, in_ready}, 32'h1);
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b1;
    in_op     = 2'd1;
    in_ch     = '0;
    in_data   = 12'd1;
    drain     = 1'b0;
    out_ready = 1'b0;
    rd_ch     = '0;
    model_reset();

    repeat (3) begin
      @(negedge clk);
      #1;
      check("reset_ready", {31'h0, in_ready}, 32'h0);
      check("reset_valid", {31'h0, out_valid}, 32'h0);
      check("reset_done", {31'h0, drain_done}, 32'h0);
    end
    in_valid = 1'b0;
    check_bank("reset");
    rst = 1'b1;
    @(negedge clk);

    do_op(1, 2, 5);
    do_op(2, 2, -7);
    do_op(2, 2, 3);
    check_bank("load_acc");
    @(negedge clk);

    do_op(1, 1, 2047);
    repeat (16) do_op(2, 1, 2047);
    check_bank("ovf_pos");
    @(negedge clk);
    do_op(1, 3, -2048);
    repeat (16) do_op(2, 3, -2048);
    check_bank("ovf_neg");
    @(negedge clk);
    do_op(3, 1, 100);
    do_op(0, 3, 100);
    check_bank("nop");
    @(negedge clk);
    do_op(1, 1, 0);
    check_bank("load_clears_ovf");
    @(negedge clk);

    for (int c = 0; c < NUM_CH; c++) do_op(1, c, 10 * (c + 1));
    do_op(2, 3, 0);
    pulse_drain(1'b0);
    run_drain(1'b1, NUM_CH);
    finish_drain("drain_bp");
    check_bank("after_drain");
    @(negedge clk);

    do_op(1, 0, 7);
    do_op(1, 2, -5);
    pulse_drain(1'b1);
    #1;
    check("collision_started", {31'h0, out_valid}, 32'h1);
    check_bank("collision");
    @(negedge clk);
    run_drain(1'b0, NUM_CH);
    finish_drain("drain_fast");

    for (int c = 0; c < NUM_CH; c++) do_op(1, c, c + 1);
    pulse_drain(1'b0);
    run_drain(1'b0, 2);
    rst = 1'b0;
    #1;
    model_reset();
    check("midrst_valid", {31'h0, out_valid}, 32'h0);
    check("midrst_done", {31'h0, drain_done}, 32'h0);
    check_bank("midrst");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("midrst_idle_valid", {31'h0, out_valid}, 32'h0);
    check("midrst_idle_done", {31'h0, drain_done}, 32'h0);
    check("midrst_idle_ready", {31'h0, in_ready}, 32'h1);
    @(negedge clk);

    for (int k = 0; k < 80; k++) begin
      do_op(int'($urandom_range(0, 3)), int'($urandom_range(0, NUM_CH - 1)),
            int'($urandom_range(0, 4095)) - 2048);
      if (k % 10 == 9) begin
        check_bank($sformatf("rand%0d", k));
        @(negedge clk);
      end
    end
    pulse_drain(1'b0);
    run_drain(1'b1, NUM_CH);
    finish_drain("rand_drain");
    check_bank("rand_final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
